jml_i2c_sync_target: RTL and testbench
======================================

Name: jml_i2c_sync_target

Overview:
- System-clock I2C target: oversamples SCL/SDA on `clk`, filters glitches and decodes START/STOP.
- Bridges register-style I2C transfers onto the register/FIFO bus: logic address byte, multi-byte writes, auto-increment reads, and a non-incrementing FIFO "hold" window with pop strobe.
- Sits between the FPGA I2C pads (open-drain, pull-down driver) and the register file / trace RAM readers.

Parameters:
- MYI2C_ADDR, 7'h10, 7-bit target address matched in the address byte.
- ADDR_W, 6, logic address width; the low ADDR_W bits of the logic address byte are used, upper bits ignored.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (min 2).
- FILT_LEN, 3, filter length: a filtered line changes only after FILT_LEN consecutive equal synchronized samples (min 1).
- HOLD_EN, 1, 1 enables the hold window.
- HOLD_TOP, 2'b11, value of addr[ADDR_W-1:ADDR_W-2] that marks the hold window.

Ports:
- clk  in  1  system clock; must be >= 16x SCL rate.
- reset_n  in  1  asynchronous active-low reset.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- sda_drv_lo  out  1  1 = pull SDA low.
- addr  out  ADDR_W  logic address.
- read  out  1  1-clk pulse; read_data is sampled in this same cycle.
- write  out  1  1-clk pulse; write_data/addr are valid in this cycle.
- write_data  out  8  last received data byte.
- read_data  in  8  combinational from addr.
- rd_pop  out  1  1-clk pulse when an ACKed read byte came from the hold window.
- hold_rd_reset  out  1  1-clk pulse when the logic address loaded falls in the hold window.
- busy  out  1  high from START until STOP or address mismatch.

Behaviour:
- Input path: SYNC_STAGES flops, then the FILT_LEN filter, giving scl_f/sda_f. Edges are detected on scl_f.
- START = sda_f falls while scl_f is high; STOP = sda_f rises while scl_f is high. Both act in any state.
- Sampling: SDA is sampled on the scl_f rise.
- Drive: sda_drv_lo changes only in the clk after an scl_f fall.
- Bit counter: 3-bit counter plus 8-bit MSB-first shift register.
- States:
  - IDLE.
  - ADDR.
  - ADDR_ACK.
  - REG.
  - REG_ACK.
  - WDATA.
  - WDATA_ACK.
  - RDATA.
  - RDATA_ACK.
  - WAIT (ignore traffic until START/STOP).
- Transitions:
  - IDLE -> ADDR on START.
  - Any state -> ADDR on START (repeated start); bit counter cleared.
  - Any state -> IDLE on STOP; sda_drv_lo = 0.
  - ADDR, 8th bit, match: -> ADDR_ACK, then drive ACK (low) for one SCL period.
  - ADDR, 8th bit, mismatch: -> IDLE, no ACK.
  - ADDR_ACK: R/W=0 -> REG; R/W=1 -> RDATA.
  - REG, 8th bit: -> REG_ACK (ACK). addr <= byte[ADDR_W-1:0] on the 8th sample. hold_rd_reset pulses if HOLD_EN and the top bits equal HOLD_TOP. Then -> WDATA.
  - WDATA, 8th bit: -> WDATA_ACK (ACK) and write pulses.
    - First data byte after REG goes to the loaded addr.
    - Each later byte goes to addr+1 (increment applied before the write pulse).
    - No increment while in the hold window.
    - Then -> WDATA.
  - RDATA entry (scl_f fall ending the ACK/NACK slot):
    - read pulses; read_data is loaded into the transmit shifter.
    - The MSB is driven (sda_drv_lo = ~bit) on that fall; 8 bits are shifted on successive falls.
  - After the 8th bit -> RDATA_ACK; SDA is released.
  - Master ACK (sda=0 at rise):
    - addr increments, wrapping modulo 2^ADDR_W; no increment in the hold window, where rd_pop pulses instead.
    - Then -> RDATA.
  - Master NACK: -> WAIT.
  - A read with no prior REG uses the current addr.
- addr persists across transactions; cleared only by reset.
- busy:
  - busy = 1 in every state except IDLE and WAIT-after-mismatch.
  - Mismatch goes to IDLE, so busy = 0.
- Reset (async, any time, including mid-byte):
  - All outputs go to 0: sda_drv_lo, addr, read, write, write_data, rd_pop, hold_rd_reset, busy.
  - State -> IDLE; filters are preset to 1 (idle bus).
- Simultaneous events:
  - START/STOP has priority over a bit edge in the same clk.
  - A write pulse already issued is never revoked.

Test Plan:
- Write: S,0x20,0x05,0xA5,P -> write=1 once with addr=0x05, write_data=0xA5; three ACKs seen low.
- Burst write, HOLD_EN=0: S,0x20,0x3F,0x11,0x22,P -> writes at addr 0x3F (0x11) and 0x00 (0x22); wrap verified.
- Read: S,0x20,0x10, Sr,0x21, master ACK, ACK, NACK, P, with read_data=addr+0x40 -> bytes 0x50,0x51,0x52 received; final addr=0x12; three read pulses.
- Hold window: S,0x20,0x30 -> hold_rd_reset pulse. Sr,0x21 with 4 bytes, ACK×3, NACK -> addr stays 0x30 and rd_pop pulses 3 times.
- Mismatch and glitch:
  - Address 0x22 -> no ACK, busy=0, no strobes.
  - A 2-clk low glitch on SCL (FILT_LEN=3) -> bit count unchanged.
- Reset mid-read: assert reset_n=0 during bit 4 of RDATA with sda_drv_lo=1 -> sda_drv_lo=0 immediately, all outputs 0. After release, a new S,0x20 is ACKed normally.

Source files
------------

// File: rtl/jml_i2c_sync_target.sv
// System-clock I2C target: filtered SCL/SDA, START/STOP decode, register-bus bridge
// with auto-increment, FIFO hold window and read/write strobes.

module jml_i2c_sync_target_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          run;

  // run counts consecutive synced samples that disagree with dout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
      run  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (sync[SYNC_STAGES-1] == dout) begin
        run <= '0;
      end else if (run == CW'(FILT_LEN - 1)) begin
        dout <= sync[SYNC_STAGES-1];
        run  <= '0;
      end else begin
        run <= run + CW'(1);
      end
    end
  end
endmodule

module jml_i2c_sync_target #(
  parameter logic [6:0] MYI2C_ADDR  = 7'h10,
  parameter int         ADDR_W      = 6,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3,
  parameter bit         HOLD_EN     = 1'b1,
  parameter logic [1:0] HOLD_TOP    = 2'b11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_drv_lo,
  output logic [ADDR_W-1:0] addr,
  output logic              read,
  output logic              write,
  output logic [7:0]        write_data,
  input  logic [7:0]        read_data,
  output logic              rd_pop,
  output logic              hold_rd_reset,
  output logic              busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
  } state_t;

  state_t     state;
  logic [1:0] line_raw, line_f;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det, in_hold;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] rx_byte;
  logic       rw, slot, first_wr, mack;

  assign line_raw = {sda_in, scl_in};

  for (genvar i = 0; i < 2; i++) begin : g_line
    jml_i2c_sync_target_filt #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
    ) u_filt (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (line_raw[i]),
      .dout   (line_f[i])
    );
  end

  assign scl_f     = line_f[0];
  assign sda_f     = line_f[1];
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte   = {shreg, sda_f};
  assign in_hold   = HOLD_EN && (addr[ADDR_W-1 -: 2] == HOLD_TOP);

  // slot: 0 before the rise inside an ACK slot, 1 after it (next fall ends the slot)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      scl_q         <= 1'b1;
      sda_q         <= 1'b1;
      bit_cnt       <= '0;
      shreg         <= '0;
      rw            <= 1'b0;
      slot          <= 1'b0;
      first_wr      <= 1'b0;
      mack          <= 1'b0;
      sda_drv_lo    <= 1'b0;
      addr          <= '0;
      read          <= 1'b0;
      write         <= 1'b0;
      write_data    <= '0;
      rd_pop        <= 1'b0;
      hold_rd_reset <= 1'b0;
      busy          <= 1'b0;
    end else begin
      scl_q         <= scl_f;
      sda_q         <= sda_f;
      read          <= 1'b0;
      write         <= 1'b0;
      rd_pop        <= 1'b0;
      hold_rd_reset <= 1'b0;
      if (start_det) begin
        state      <= S_ADDR;
        bit_cnt    <= '0;
        slot       <= 1'b0;
        sda_drv_lo <= 1'b0;
        busy       <= 1'b1;
      end else if (stop_det) begin
        state      <= S_IDLE;
        sda_drv_lo <= 1'b0;
        busy       <= 1'b0;
      end else if (read) begin
        // read_data is valid in the strobe cycle: load shifter, present MSB
        shreg      <= read_data[6:0];
        sda_drv_lo <= ~read_data[7];
      end else if (scl_rise) begin
        case (state)
          S_ADDR, S_REG, S_WDATA: begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              slot <= 1'b0;
              if (state == S_ADDR) begin
                if (rx_byte[7:1] == MYI2C_ADDR) begin
                  state <= S_ADDR_ACK;
                  rw    <= rx_byte[0];
                end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
              end else if (state == S_REG) begin
                addr          <= rx_byte[ADDR_W-1:0];
                hold_rd_reset <= HOLD_EN && (rx_byte[ADDR_W-1 -: 2] == HOLD_TOP);
                first_wr      <= 1'b1;
                state         <= S_REG_ACK;
              end else begin
                write_data <= rx_byte;
                write      <= 1'b1;
                first_wr   <= 1'b0;
                if (!first_wr && !in_hold) addr <= addr + ADDR_W'(1);
                state      <= S_WDATA_ACK;
              end
            end
          end
          S_RDATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_RDATA_ACK;
              slot  <= 1'b0;
            end
          end
          S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: slot <= 1'b1;
          S_RDATA_ACK: begin
            slot <= 1'b1;
            mack <= ~sda_f;
            if (!sda_f) begin
              if (in_hold) rd_pop <= 1'b1;
              else         addr   <= addr + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
            if (!slot) begin
              sda_drv_lo <= 1'b1;
            end else begin
              sda_drv_lo <= 1'b0;
              bit_cnt    <= '0;
              if (state == S_ADDR_ACK && rw) begin
                state <= S_RDATA;
                read  <= 1'b1;
              end else if (state == S_ADDR_ACK) begin
                state <= S_REG;
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            sda_drv_lo <= ~shreg[6];
            shreg      <= {shreg[5:0], 1'b0};
          end
          S_RDATA_ACK: begin
            if (!slot) begin
              sda_drv_lo <= 1'b0;
            end else if (mack) begin
              state   <= S_RDATA;
              read    <= 1'b1;
              bit_cnt <= '0;
            end else begin
              state <= S_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jml_i2c_sync_target.sv
// Bench for jml_i2c_sync_target: bit-banged I2C master, write vector table,
// directed read/hold/glitch/reset sequences and randomized transactions vs a model.

module tb_jml_i2c_sync_target;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_bus;
  logic       drv0, rd0, wr0, pop0, hrr0, busy0;
  logic       drv1, rd1, wr1, pop1, hrr1, busy1;
  logic [5:0] addr0, addr1;
  logic [7:0] wd0, wd1, rdd0, rdd1;
  logic       rd_ovr_en = 1'b0;
  logic [7:0] rd_ovr = 8'h00;

  assign sda_bus = sda_m & ~drv0 & ~drv1;
  assign rdd0    = rd_ovr_en ? rd_ovr : {2'b01, addr0};
  assign rdd1    = {2'b01, addr1};

  always #5 clk = ~clk;

  jml_i2c_sync_target u_dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_drv_lo(drv0), .addr(addr0), .read(rd0), .write(wr0), .write_data(wd0),
    .read_data(rdd0), .rd_pop(pop0), .hold_rd_reset(hrr0), .busy(busy0)
  );

  jml_i2c_sync_target #(.MYI2C_ADDR(7'h12), .HOLD_EN(1'b0)) u_nh (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_drv_lo(drv1), .addr(addr1), .read(rd1), .write(wr1), .write_data(wd1),
    .read_data(rdd1), .rd_pop(pop1), .hold_rd_reset(hrr1), .busy(busy1)
  );

  int          nvec = 0, nerr = 0;
  int          n_rd0 = 0, n_pop0 = 0, n_hrr0 = 0, n_strb1 = 0;
  logic [13:0] wr_q0[$];
  logic [13:0] wr_q1[$];
  logic [5:0]  m_addr;

  always @(negedge clk) begin
    if (wr0)  wr_q0.push_back({addr0, wd0});
    if (wr1)  wr_q1.push_back({addr1, wd1});
    if (rd0)  n_rd0++;
    if (pop0) n_pop0++;
    if (hrr0) n_hrr0++;
    if (rd1 || pop1 || hrr1) n_strb1++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  // one SCL period: low phase with data change, high phase with sample
  task automatic slot(input logic b, input logic glitch, output logic r);
    wq(); sda_m = b; wq(); scl_m = 1'b1; wq();
    if (glitch) begin
      scl_m = 1'b0;
      repeat (2) @(negedge clk);
      scl_m = 1'b1;
    end
    r = sda_bus; wq(); scl_m = 1'b0;
  endtask

  task automatic start_c();
    wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0;
  endtask

  task automatic stop_c();
    wq(); sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq(2);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int gb, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) slot(d[i], (7 - i) == gb, r);
    slot(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      slot(1'b1, 1'b0, r);
      d[i] = r;
    end
    slot(~mack, 1'b0, r);
  endtask

  task automatic rnd_write();
    int          n, acks, hrr_s;
    logic [7:0]  rb, d;
    logic [5:0]  wa;
    logic        a;
    logic [13:0] exp_q[$];
    n = $urandom_range(1, 3);
    rb = 8'($urandom);
    hrr_s = n_hrr0;
    acks = 0;
    wr_q0.delete();
    start_c();
    wr_byte(8'h20, -1, a); acks += int'(a);
    wr_byte(rb, -1, a);    acks += int'(a);
    wa = rb[5:0];
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      if (i > 0 && wa[5:4] != 2'b11) wa = wa + 6'd1;
      exp_q.push_back({wa, d});
      wr_byte(d, -1, a); acks += int'(a);
    end
    stop_c();
    m_addr = wa;
    chk("rnd_wr_acks", acks, n + 2);
    chk("rnd_wr_hold_reset", n_hrr0 - hrr_s, (rb[5:4] == 2'b11) ? 1 : 0);
    chk("rnd_wr_count", wr_q0.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q0.size(); i++)
      chk("rnd_wr_addr_data", wr_q0[i], exp_q[i]);
  endtask

  task automatic rnd_read();
    int         n, rd_s, pop_s, exp_pop;
    logic       setreg, a;
    logic [7:0] rb, d;
    n = $urandom_range(1, 4);
    setreg = 1'($urandom_range(0, 1));
    rb = 8'($urandom);
    rd_s = n_rd0; pop_s = n_pop0; exp_pop = 0;
    start_c();
    if (setreg) begin
      wr_byte(8'h20, -1, a);
      wr_byte(rb, -1, a);
      m_addr = rb[5:0];
      start_c();
    end
    wr_byte(8'h21, -1, a);
    chk("rnd_rd_addr_ack", a, 1'b1);
    for (int i = 0; i < n; i++) begin
      rd_byte(i < n - 1, d);
      chk("rnd_rd_byte", d, {2'b01, m_addr});
      if (i < n - 1) begin
        if (m_addr[5:4] == 2'b11) exp_pop++;
        else m_addr = m_addr + 6'd1;
      end
    end
    stop_c();
    chk("rnd_rd_pulses", n_rd0 - rd_s, n);
    chk("rnd_rd_pops", n_pop0 - pop_s, exp_pop);
    chk("rnd_rd_final_addr", addr0, m_addr);
  endtask

  typedef struct {
    logic [7:0] dev, regb, data;
    int         exp_acks;
    int         exp_wr;
    logic [5:0] exp_wa;
    int         exp_hrr;
  } wvec_t;

  wvec_t tbl[5];

  initial begin
    logic       a;
    logic [7:0] d;
    int         acks, rd_s, pop_s, hrr_s, s1;

    tbl[0] = '{8'h20, 8'h05, 8'hA5, 3, 1, 6'h05, 0};
    tbl[1] = '{8'h20, 8'h30, 8'h3C, 3, 1, 6'h30, 1};
    tbl[2] = '{8'h22, 8'h05, 8'h99, 0, 0, 6'h00, 0};
    tbl[3] = '{8'h20, 8'h2A, 8'h00, 3, 1, 6'h2A, 0};
    tbl[4] = '{8'h20, 8'hFF, 8'h5A, 3, 1, 6'h3F, 1};

    repeat (5) @(negedge clk);
    chk("reset_outputs_main", {drv0, addr0, rd0, wr0, wd0, pop0, hrr0, busy0}, 0);
    chk("reset_outputs_nohold", {drv1, addr1, rd1, wr1, wd1, pop1, hrr1, busy1}, 0);
    reset_n = 1'b1;
    wq(2);

    // single-byte register writes
    for (int v = 0; v < 5; v++) begin
      wr_q0.delete();
      hrr_s = n_hrr0; rd_s = n_rd0; s1 = n_strb1;
      acks = 0;
      start_c();
      wr_byte(tbl[v].dev, -1, a);  acks += int'(a);
      chk("tbl_busy_after_addr", busy0, tbl[v].exp_acks != 0);
      wr_byte(tbl[v].regb, -1, a); acks += int'(a);
      wr_byte(tbl[v].data, -1, a); acks += int'(a);
      stop_c();
      chk("tbl_acks", acks, tbl[v].exp_acks);
      chk("tbl_write_count", wr_q0.size(), tbl[v].exp_wr);
      if (wr_q0.size() > 0) chk("tbl_write_addr_data", wr_q0[0], {tbl[v].exp_wa, tbl[v].data});
      chk("tbl_hold_reset", n_hrr0 - hrr_s, tbl[v].exp_hrr);
      chk("tbl_no_read", n_rd0 - rd_s, 0);
      chk("tbl_busy_after_stop", busy0, 1'b0);
      chk("tbl_other_target_quiet", n_strb1 - s1, 0);
    end

    // burst write with address wrap, hold window disabled
    wr_q1.delete();
    acks = 0;
    start_c();
    wr_byte(8'h24, -1, a); acks += int'(a);
    wr_byte(8'h3F, -1, a); acks += int'(a);
    wr_byte(8'h11, -1, a); acks += int'(a);
    wr_byte(8'h22, -1, a); acks += int'(a);
    stop_c();
    chk("burst_acks", acks, 4);
    chk("burst_count", wr_q1.size(), 2);
    if (wr_q1.size() == 2) begin
      chk("burst_first", wr_q1[0], {6'h3F, 8'h11});
      chk("burst_wrap", wr_q1[1], {6'h00, 8'h22});
    end

    // auto-increment read after register set + repeated start
    rd_s = n_rd0; wr_q0.delete();
    start_c();
    wr_byte(8'h20, -1, a);
    wr_byte(8'h10, -1, a);
    start_c();
    wr_byte(8'h21, -1, a);
    chk("read_addr_ack", a, 1'b1);
    rd_byte(1'b1, d); chk("read_byte0", d, 8'h50);
    rd_byte(1'b1, d); chk("read_byte1", d, 8'h51);
    rd_byte(1'b0, d); chk("read_byte2", d, 8'h52);
    chk("read_busy_in_wait", busy0, 1'b1);
    stop_c();
    chk("read_final_addr", addr0, 6'h12);
    chk("read_pulses", n_rd0 - rd_s, 3);
    chk("read_no_write", wr_q0.size(), 0);

    // hold window: address stays put, pops on ACKed bytes
    rd_s = n_rd0; pop_s = n_pop0; hrr_s = n_hrr0;
    start_c();
    wr_byte(8'h20, -1, a);
    wr_byte(8'h30, -1, a);
    chk("hold_reset_pulse", n_hrr0 - hrr_s, 1);
    start_c();
    wr_byte(8'h21, -1, a);
    for (int i = 0; i < 4; i++) begin
      rd_byte(i < 3, d);
      chk("hold_byte", d, 8'h70);
    end
    stop_c();
    chk("hold_addr", addr0, 6'h30);
    chk("hold_pops", n_pop0 - pop_s, 3);
    chk("hold_reads", n_rd0 - rd_s, 4);

    // 2-clk SCL glitch inside the address byte must not count as a bit
    wr_q0.delete();
    acks = 0;
    start_c();
    wr_byte(8'h20, 3, a);  acks += int'(a);
    wr_byte(8'h0C, -1, a); acks += int'(a);
    wr_byte(8'h3C, -1, a); acks += int'(a);
    stop_c();
    chk("glitch_acks", acks, 3);
    chk("glitch_write", (wr_q0.size() == 1) ? wr_q0[0] : 14'h3FFF, {6'h0C, 8'h3C});

    // async reset while the target is driving a 0 data bit
    rd_ovr_en = 1'b1; rd_ovr = 8'hEF;
    start_c();
    wr_byte(8'h21, -1, a);
    for (int i = 0; i < 3; i++) slot(1'b1, 1'b0, a);
    wq(); sda_m = 1'b1; wq(); scl_m = 1'b1; wq();
    chk("rst_pre_drive_low", drv0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_outputs", {drv0, addr0, rd0, wr0, wd0, pop0, hrr0, busy0}, 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    rd_ovr_en = 1'b0;
    wq(2);
    start_c();
    wr_byte(8'h20, -1, a);
    chk("rst_after_ack", a, 1'b1);
    stop_c();
    chk("rst_addr_cleared", addr0, 6'h00);

    // randomized transactions against the model
    m_addr = 6'h00;
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 0) rnd_write();
      else rnd_read();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
